// File: rtl/mmio_io_responder.sv
// mmio_io_responder
//   Memory-mapped I/O responder between the processor data-memory port and
//   the board peripherals.
//   - Debounced button levels become sticky press events (clear on read).
//   - Stores to ADDR_OUT are buffered in a small FIFO that drains to the VGA
//     controller over a valid/ready handshake.
//   - A status word reports the FIFO fill level and a sticky overflow flag.
//
// Ports:
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   mem_addr   in  32   processor data address
//   mem_wren   in   1   store strobe (one cycle per store)
//   mem_rden   in   1   load strobe (one cycle per load)
//   mem_wdata  in  32   store data
//   ram_rdata  in  32   RAM read data, passed through for non-I/O addresses
//   mem_rdata  out 32   read data to the processor (combinational)
//   btn        in   5   debounced button levels {D,U,R,L,C}
//   out_data   out 32   FIFO head toward the VGA controller (0 when empty)
//   out_valid  out  1   FIFO non-empty
//   out_ready  in   1   VGA controller accepts the head this cycle
module mmio_io_responder #(
  parameter logic [31:0] ADDR_BTNC  = 32'd1000,
  parameter logic [31:0] ADDR_OUT   = 32'd2000,
  parameter logic [31:0] ADDR_BTNL  = 32'd3000,
  parameter logic [31:0] ADDR_BTNR  = 32'd4000,
  parameter logic [31:0] ADDR_BTNU  = 32'd5000,
  parameter logic [31:0] ADDR_BTND  = 32'd6000,
  parameter logic [31:0] ADDR_STAT  = 32'd7000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_wren,
  input  logic        mem_rden,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] ram_rdata,
  output logic [31:0] mem_rdata,
  input  logic [4:0]  btn,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Button index order matches btn: {D,U,R,L,C}
  localparam logic [31:0] BTN_ADDR [5] = '{ADDR_BTNC, ADDR_BTNL, ADDR_BTNR,
                                           ADDR_BTNU, ADDR_BTND};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [4:0]    btn_q;
  logic          armed_q;
  logic [4:0]    evt_q,  evt_d;
  logic          ovf_q,  ovf_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [4:0] btn_sel;
  logic       stat_sel;
  logic       out_sel;

  assign stat_sel = (mem_addr == ADDR_STAT);
  assign out_sel  = (mem_addr == ADDR_OUT);

  // ---------------------------------------------------------------------
  // Button events
  // ---------------------------------------------------------------------
  logic [4:0] rise;
  logic [4:0] rd_clr;

  // No rises on the arming clock, so a button held through reset is silent.
  assign rise = armed_q ? (btn & ~btn_q) : 5'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      assign btn_sel[gi] = (mem_addr == BTN_ADDR[gi]);
      assign rd_clr[gi]  = mem_rden & btn_sel[gi];
      // A rise in the same cycle as the clearing read keeps the event.
      assign evt_d[gi]   = rise[gi] | (evt_q[gi] & ~rd_clr[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic push_req, push_ok, pop, full, drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign push_req  = mem_wren & out_sel;
  assign pop       = out_valid & out_ready;
  // When full, a concurrent pop frees the slot this push lands in.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + PW'(1);
    if (pop)     head_d = head_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drop sets overflow with priority over the clearing status read.
  assign ovf_d = drop | (ovf_q & ~(mem_rden & stat_sel));

  assign out_data = out_valid ? fifo_mem[head_q] : 32'd0;

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    mem_rdata = ram_rdata;
    if (out_sel) begin
      mem_rdata = 32'd0;
    end else if (stat_sel) begin
      mem_rdata = {23'd0, {(8 - CW){1'b0}}, count_q, ovf_q};
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btn_sel[i]) mem_rdata = {31'd0, evt_q[i]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_q   <= 5'd0;
      armed_q <= 1'b0;
      evt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      btn_q   <= btn;
      armed_q <= 1'b1;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[tail_q] <= mem_wdata;
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
module tb_mmio_io_responder;

  logic        clock;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic        mem_rden;
  logic [31:0] mem_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem_rdata;
  logic [4:0]  btn;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  mmio_io_responder dut (
    .clock     (clock),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wren  (mem_wren),
    .mem_rden  (mem_rden),
    .mem_wdata (mem_wdata),
    .ram_rdata (ram_rdata),
    .mem_rdata (mem_rdata),
    .btn       (btn),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle load; data sampled mid-cycle, before the edge.
  task automatic load(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_rden = 1'b1;
    #2;
    d = mem_rdata;
    tick();
    mem_rden = 1'b0;
    mem_addr = 32'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] v);
    mem_addr  = a;
    mem_wdata = v;
    mem_wren  = 1'b1;
    tick();
    mem_wren  = 1'b0;
    mem_addr  = 32'd0;
  endtask

  // Check head each cycle while draining with out_ready=1.
  task automatic drain(input string tag, input logic [31:0] exp_q[$]);
    out_ready = 1'b1;
    foreach (exp_q[k]) begin
      #1;
      check($sformatf("%s_valid%0d", tag, k), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s_data%0d", tag, k), out_data, exp_q[k]);
      @(posedge clock);
      #1;
    end
    #1;
    check({tag, "_empty_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_empty_data"}, out_data, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic [31:0] q[$];

  initial begin
    reset     = 1'b0;
    mem_addr  = 32'd0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    mem_wdata = 32'd0;
    ram_rdata = 32'hCAFE_F00D;
    btn       = 5'b00001;
    out_ready = 1'b0;

    // --- reset hold ---
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    mem_addr = 32'd1000; #1; check("rst_rd1000", mem_rdata, 32'd0);
    mem_addr = 32'd3000; #1; check("rst_rd3000", mem_rdata, 32'd0);
    mem_addr = 32'd7000; #1; check("rst_rd7000", mem_rdata, 32'd0);
    mem_addr = 32'd0;
    tick();
    reset = 1'b1;
    tick(); tick();
    load(32'd1000, rd); check("held_btn_no_evt", rd, 32'd0);

    // --- left button pulse ---
    btn = 5'b00011;
    tick(); tick(); tick();
    btn = 5'b00001;
    tick();
    load(32'd3000, rd); check("btnl_evt", rd, 32'd1);
    load(32'd3000, rd); check("btnl_cleared", rd, 32'd0);
    load(32'd1000, rd); check("btnc_unaffected", rd, 32'd0);

    // --- rise coincident with clearing read ---
    btn = 5'b00000; tick();
    btn = 5'b00001; tick();           // evt[0] set
    btn = 5'b00000; tick();           // btn_q[0]=0, evt stays
    btn = 5'b00001;                   // new rise during the read
    load(32'd1000, rd); check("btnc_rise_on_read", rd, 32'd1);
    load(32'd1000, rd); check("btnc_kept", rd, 32'd1);
    load(32'd1000, rd); check("btnc_cleared", rd, 32'd0);

    // --- overflow and drain ---
    store(32'd2000, 32'hA);
    store(32'd2000, 32'hB);
    store(32'd2000, 32'hC);
    store(32'd2000, 32'hD);
    store(32'd2000, 32'hE);
    load(32'd2000, rd); check("rd_out_addr_zero", rd, 32'd0);
    check("stall_head", out_data, 32'hA);
    tick();
    check("stall_head_stable", out_data, 32'hA);
    load(32'd7000, rd); check("stat_full_ovf", rd, 32'h9);
    load(32'd7000, rd); check("stat_ovf_cleared", rd, 32'h8);
    q = '{32'hA, 32'hB, 32'hC, 32'hD};
    drain("drain1", q);

    // --- full with simultaneous push and pop ---
    store(32'd2000, 32'h11);
    store(32'd2000, 32'h12);
    store(32'd2000, 32'h13);
    store(32'd2000, 32'h14);
    mem_addr  = 32'd2000;
    mem_wdata = 32'hF;
    mem_wren  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("full_pp_head", out_data, 32'h11);
    tick();
    mem_wren  = 1'b0;
    out_ready = 1'b0;
    mem_addr  = 32'd0;
    load(32'd7000, rd); check("stat_full_no_ovf", rd, 32'h8);
    q = '{32'h12, 32'h13, 32'h14, 32'hF};
    drain("drain2", q);

    // --- push into empty FIFO, no bypass ---
    out_ready = 1'b1;
    mem_addr  = 32'd2000;
    mem_wdata = 32'h55;
    mem_wren  = 1'b1;
    #1;
    check("empty_push_no_bypass", {31'd0, out_valid}, 32'd0);
    tick();
    mem_wren = 1'b0;
    mem_addr = 32'd0;
    #1;
    check("empty_push_valid", {31'd0, out_valid}, 32'd1);
    check("empty_push_data", out_data, 32'h55);
    tick();
    check("empty_push_popped", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    load(32'd7000, rd); check("stat_empty", rd, 32'h0);
    load(32'd42, rd); check("ram_passthru", rd, 32'hCAFE_F00D);
    ram_rdata = 32'h0000_1234;
    load(32'd8000, rd); check("ram_passthru2", rd, 32'h0000_1234);

    // --- asynchronous reset mid-transfer ---
    store(32'd2000, 32'h77);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", out_data, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder between the processor data-memory port and the board peripherals.
- Converts debounced button levels into sticky press events. The processor reads these events and they clear on read.
- Buffers processor writes to the output address in a small FIFO. The FIFO drains to the VGA controller over a valid/ready handshake.
- Reports FIFO status and overflow to the processor.

Parameters:
- ADDR_BTNC, 1000, address of centre-button event word
- ADDR_OUT, 2000, write-only output mailbox address
- ADDR_BTNL, 3000, left-button event address
- ADDR_BTNR, 4000, right-button event address
- ADDR_BTNU, 5000, up-button event address
- ADDR_BTND, 6000, down-button event address
- ADDR_STAT, 7000, status word address
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_addr  in  32  processor data address
- mem_wren  in  1  processor store strobe, one cycle per store
- mem_rden  in  1  processor load strobe, one cycle per load
- mem_wdata  in  32  processor store data
- ram_rdata  in  32  RAM read data, passed through for non-I/O addresses
- mem_rdata  out  32  read data returned to the processor (combinational)
- btn  in  5  debounced button levels, {D,U,R,L,C}
- out_data  out  32  FIFO head toward the VGA controller
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  VGA controller accepts the head this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears event flags, overflow flag, FIFO pointers and count.
  - Clears btn_q and the armed bit.
  - out_valid=0 and out_data=0.
- Arming:
  - The first clock after reset release loads btn_q=btn and sets armed=1.
  - No events are generated on that clock, so a button held through reset produces no event.
- Event detection (armed=1):
  - rise[i] = btn[i] & ~btn_q[i].
  - btn_q is updated every clock.
  - evt[i] is set on rise[i] and stays set until read.
- Button read:
  - When mem_addr equals a button address, mem_rdata = {31'b0, evt[i]} combinationally.
  - If mem_rden=1 on that address, evt[i] clears at the next edge.
  - A rise on the same cycle wins: evt stays 1, so the event is not lost.
- Status read (mem_addr==ADDR_STAT):
  - mem_rdata = {23'b0, count[7:0], overflow}.
  - count ranges 0..FIFO_DEPTH.
  - mem_rden clears overflow unless a dropped push occurs the same cycle (set wins).
- ADDR_OUT reads return 0.
- All other addresses: mem_rdata = ram_rdata.
- Push: mem_wren=1 and mem_addr==ADDR_OUT.
  - If not full, mem_wdata is written at the tail; tail and count increment.
  - If full and no pop this cycle, the data is dropped and overflow is set.
- Pop: out_valid & out_ready. The head pointer increments and count decrements.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees the slot the same cycle.
  - When empty, no pop occurs (out_valid=0). The pushed word becomes visible the next cycle; there is no bypass.
- Outputs:
  - out_valid = (count != 0).
  - out_data = mem[head] when valid, else 0. It is stable while out_valid=1 and out_ready=0.
- Pointer arithmetic:
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - count is log2(FIFO_DEPTH)+1 bits.
- Writes to button or status addresses are ignored; the RAM handles them separately.
- Reset asserted mid-transfer discards FIFO contents; out_valid drops immediately (asynchronous).

Test Plan:
- Reset hold → out_valid=0, out_data=0; reads at 1000/3000/7000 return 0. Release reset with btn=5'b00001 held → read 1000 returns 0 (no event).
- Pulse btn[1] (L) for 3 cycles, then load 3000 with mem_rden → returns 1. Second load → returns 0. Addr 1000 is unaffected (0).
- Rise on btn[0] in the same cycle as a mem_rden load of 1000 with evt=1 → returns 1 and evt stays 1. Next load returns 1, the one after returns 0.
- out_ready=0; store 0xA,0xB,0xC,0xD,0xE to 2000 → status reads 0x9 (count=4, overflow=1). Status read clears overflow → next status reads 0x8. Raise out_ready → out_data sequence A,B,C,D, then out_valid=0.
- FIFO full with out_ready=1 and a store of 0xF to 2000 in the same cycle → no overflow, count stays 4, 0xF drains fifth.
- Store 0x55 into the empty FIFO with out_ready=1 → out_valid rises the next cycle with out_data=0x55, pops that cycle, count returns to 0. Load of addr 42 returns ram_rdata unchanged.
